// File: rtl/vram_frame_ctrl.sv
// vram_frame_ctrl: multi-frame VRAM with front/back buffer flip on vsync and a back-buffer fill engine.
module vram_frame_ctrl #(
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 49152,
  parameter int NUM_FRAMES  = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_READY,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              SWAP_REQ,
  input  logic              VSYNC,
  output logic              SWAP_DONE,
  input  logic              CLEAR_REQ,
  input  logic [DATA_W-1:0] CLEAR_COLOR,
  output logic              CLEAR_BUSY,
  output logic [1:0]        FRONT_IDX
);
  localparam int DEPTH = NUM_FRAMES * FRAME_WORDS;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FW = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [1:0] LAST = 2'(NUM_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, CLEARING, SWAP_WAIT} state_t;
  state_t state, state_n;
  logic swap_pend, swap_pend_n;
  logic [ADDR_W-1:0] clr_cnt, wr_a;
  logic [DATA_W-1:0] clr_color, wr_d;
  logic [1:0] front_idx, back_idx;
  logic [PW-1:0] rd_phys, wr_phys;
  logic clr_last, flip, wr_go, wr_in, rd_in;
  logic [DATA_W-1:0] mem [DEPTH];
  assign WR_READY = state == IDLE;
  assign CLEAR_BUSY = state == CLEARING;
  assign FRONT_IDX = front_idx;
  always_comb begin
    back_idx = front_idx == LAST ? 2'd0 : front_idx + 2'd1;
    clr_last = {1'b0, clr_cnt} == FW - 1'b1;
    flip = state == SWAP_WAIT && VSYNC;
    wr_in = {1'b0, WR_ADDR} < FW;
    rd_in = {1'b0, RD_ADDR} < FW;
    wr_go = state == CLEARING || (state == IDLE && WR_EN && wr_in);
    wr_a = state == CLEARING ? clr_cnt : WR_ADDR;
    wr_d = state == CLEARING ? clr_color : WR_DATA;
    wr_phys = PW'(back_idx) * PW'(FRAME_WORDS) + PW'(wr_a);
    rd_phys = PW'(front_idx) * PW'(FRAME_WORDS) + PW'(RD_ADDR);
  end
  always_comb begin
    state_n = state;
    swap_pend_n = swap_pend;
    case (state)
      IDLE: begin
        if (CLEAR_REQ) begin
          state_n = CLEARING;
          swap_pend_n = SWAP_REQ;
        end else if (SWAP_REQ) state_n = SWAP_WAIT;
      end
      CLEARING: begin
        if (clr_last) begin
          state_n = (swap_pend || SWAP_REQ) ? SWAP_WAIT : IDLE;
          swap_pend_n = 1'b0;
        end else if (SWAP_REQ) swap_pend_n = 1'b1;
      end
      SWAP_WAIT: state_n = VSYNC ? IDLE : SWAP_WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      swap_pend <= 1'b0;
      front_idx <= 2'd0;
      SWAP_DONE <= 1'b0;
      clr_cnt <= '0;
      clr_color <= '0;
      RD_DATA <= '0;
      RD_VALID <= 1'b0;
    end else begin
      state <= state_n;
      swap_pend <= swap_pend_n;
      front_idx <= flip ? back_idx : front_idx;
      SWAP_DONE <= flip;
      clr_cnt <= (state == CLEARING && !clr_last) ? clr_cnt + 1'b1 : '0;
      clr_color <= (state == IDLE && CLEAR_REQ) ? CLEAR_COLOR : clr_color;
      RD_VALID <= RD_EN;
      if (RD_EN) RD_DATA <= rd_in ? mem[rd_phys] : '0;
    end
  end
  // Memory has no reset so a reset mid-fill keeps the words already written.
  always_ff @(posedge CLK) begin
    if (wr_go) mem[wr_phys] <= wr_d;
  end
endmodule
